sensor_linebuf_ctrl: RTL and testbench

//  Line-delay controller for the sensor pixel path. Drives one external simple dual-port MEM
//  (sensor_sdpram, 1-cycle registered read, ren-gated).

---
 rtl/sensor_linebuf_ctrl.sv | 132 +++++++++++++
 tb/tb_sensor_linebuf_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_linebuf_ctrl.sv
// Line-delay controller: pairs each pixel with the same column of the previous line via an external SDP RAM.
// Latency: outputs exactly 1 cycle after the input pixel; RAM read issued combinationally, write trails by 1 cycle.
// Backpressure: none; every pixel accepted while a frame is open is emitted, gaps (s_valid=0) just hold state.
module sensor_linebuf_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_sof,
    input  logic                           s_eol,
    output logic [DATA_WIDTH-1:0]          ram_din,
    output logic [$clog2(MAX_WIDTH)-1:0]   ram_waddr,
    output logic                           ram_we,
    output logic [$clog2(MAX_WIDTH)-1:0]   ram_raddr,
    output logic                           ram_ren,
    input  logic [DATA_WIDTH-1:0]          ram_dout,
    output logic                           m_valid,
    output logic [DATA_WIDTH-1:0]          m_cur,
    output logic [DATA_WIDTH-1:0]          m_prev,
    output logic                           m_prev_ok,
    output logic                           m_sof,
    output logic                           m_eol,
    output logic                           ovf_err
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAXW = CW'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, FIRST, LINE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_prev_len;
    logic                  r_we;
    logic [AW-1:0]         r_waddr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_cur;
    logic                  r_m_ok;
    logic                  r_m_sof;
    logic                  r_m_eol;
    logic                  r_fwd_sel;
    logic [DATA_WIDTH-1:0] r_fwd_dat;
    logic                  r_ovf;

    logic                  w_accept;
    logic [CW-1:0]         w_col;
    logic                  w_in_range;
    logic                  w_rd_req;
    logic [AW-1:0]         w_addr;
    logic                  w_coll;
    logic                  w_ok;
    logic [CW-1:0]         w_col_inc;

    always_comb begin
        w_accept   = s_valid && ((r_state != IDLE) || s_sof);
        w_col      = s_sof ? '0 : r_col;
        w_in_range = (w_col < MAXW);
        w_rd_req   = s_valid && (r_state != IDLE) && w_in_range;
        w_addr     = w_col[AW-1:0];
        // Back-to-back 1-pixel lines would read the column still being written; forward instead.
        w_coll     = w_rd_req && r_we && (r_waddr == w_addr);
        w_ok       = w_accept && !s_sof && (r_state == LINE) && (w_col < r_prev_len) && w_in_range;
        w_col_inc  = w_in_range ? (w_col + CW'(1)) : w_col;
    end

    assign ram_ren   = w_rd_req && !w_coll;
    assign ram_raddr = w_rd_req ? w_addr : '0;
    assign ram_we    = r_we;
    assign ram_waddr = r_waddr;
    assign ram_din   = r_din;

    assign m_valid   = r_m_valid;
    assign m_cur     = r_m_cur;
    assign m_prev_ok = r_m_ok;
    assign m_prev    = r_m_ok ? (r_fwd_sel ? r_fwd_dat : ram_dout) : '0;
    assign m_sof     = r_m_sof;
    assign m_eol     = r_m_eol;
    assign ovf_err   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_prev_len <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_din      <= '0;
            r_m_valid  <= 1'b0;
            r_m_cur    <= '0;
            r_m_ok     <= 1'b0;
            r_m_sof    <= 1'b0;
            r_m_eol    <= 1'b0;
            r_fwd_sel  <= 1'b0;
            r_fwd_dat  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_we      <= w_accept && w_in_range;
            r_waddr   <= w_accept ? w_addr : '0;
            r_din     <= w_accept ? s_data : '0;
            r_m_valid <= w_accept;
            r_m_cur   <= w_accept ? s_data : '0;
            r_m_ok    <= w_ok;
            r_m_sof   <= w_accept && s_sof;
            r_m_eol   <= w_accept && s_eol;
            r_fwd_sel <= w_coll;
            r_fwd_dat <= r_din;
            if (w_accept) begin
                if (s_eol) begin
                    r_state    <= LINE;
                    r_col      <= '0;
                    r_prev_len <= w_in_range ? (w_col + CW'(1)) : MAXW;
                end else begin
                    if (s_sof) begin
                        r_state <= FIRST;
                    end
                    r_col <= w_col_inc;
                end
                if (s_sof) begin
                    r_ovf <= 1'b0;
                end else if (!w_in_range) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_linebuf_ctrl.sv
// Bench for sensor_linebuf_ctrl: hand-derived vector table, then directed and random frames
// checked against a queue-based model of "previous complete line" semantics.
module tb_sensor_linebuf_ctrl;

    localparam int DW  = 8;
    localparam int MW  = 16;
    localparam int AW  = $clog2(MW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_eol = 1'b0;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_waddr;
    logic          ram_we;
    logic [AW-1:0] ram_raddr;
    logic          ram_ren;
    logic [DW-1:0] ram_dout = '0;
    logic          m_valid;
    logic [DW-1:0] m_cur;
    logic [DW-1:0] m_prev;
    logic          m_prev_ok;
    logic          m_sof;
    logic          m_eol;
    logic          ovf_err;

    int checks = 0;
    int failures = 0;

    sensor_linebuf_ctrl #(.DATA_WIDTH(DW), .MAX_WIDTH(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .ram_din(ram_din), .ram_waddr(ram_waddr), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_dout(ram_dout),
        .m_valid(m_valid), .m_cur(m_cur), .m_prev(m_prev), .m_prev_ok(m_prev_ok),
        .m_sof(m_sof), .m_eol(m_eol), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, 1-cycle registered read gated by ren; preloaded with junk.
    logic [DW-1:0] mem [MW] = '{default: 8'hA5};
    always @(posedge clk) begin
        if (ram_we)  mem[ram_waddr] <= ram_din;
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    // {valid, cur, prev, prev_ok, sof, eol, ovf}
    typedef logic [2*DW+4:0] out_t;

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            sof;
        bit            eol;
        out_t          exp;
    } vec_t;

    function automatic out_t mk(bit v, logic [DW-1:0] c, logic [DW-1:0] p, bit ok, bit sf, bit el, bit ov);
        return {v, c, p, ok, sf, el, ov};
    endfunction

    // Reference model: previous complete line kept as a queue of pixels.
    bit            md_in_frame;
    bit            md_first;
    int            md_col;
    bit            md_ovf;
    logic [DW-1:0] md_cur_q[$];
    logic [DW-1:0] md_prev_q[$];

    task automatic model_reset();
        md_in_frame = 0; md_first = 1; md_col = 0; md_ovf = 0;
        md_cur_q.delete(); md_prev_q.delete();
    endtask

    task automatic drive_check(input bit v, input logic [DW-1:0] d, input bit sof, input bit eol,
                               input out_t exp, input string tag);
        out_t got;
        @(negedge clk);
        s_valid = v; s_data = d; s_sof = sof; s_eol = eol;
        #1;
        if (ram_we && ram_ren) begin
            checks++;
            if (ram_waddr == ram_raddr) begin
                failures++;
                $display("FAIL collision %s: we/ren both at addr %0d (required different)", tag, ram_waddr);
            end
        end
        @(posedge clk);
        #1;
        got = {m_valid, m_cur, m_prev, m_prev_ok, m_sof, m_eol, ovf_err};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got v=%b cur=%h prev=%h ok=%b sof=%b eol=%b ovf=%b, required v=%b cur=%h prev=%h ok=%b sof=%b eol=%b ovf=%b",
                     tag, got[20], got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                     exp[20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit sof, input bit eol, input string tag);
        out_t e;
        bit acc, ok;
        logic [DW-1:0] p;
        acc = v && (md_in_frame || sof);
        e = mk(0, 0, 0, 0, 0, 0, md_ovf);
        if (acc) begin
            if (sof) begin
                md_in_frame = 1; md_first = 1; md_col = 0; md_ovf = 0; md_cur_q.delete();
            end
            ok = !md_first && (md_col < md_prev_q.size()) && (md_col < MW);
            p  = ok ? md_prev_q[md_col] : '0;
            if (md_col >= MW) md_ovf = 1;
            else md_cur_q.push_back(d);
            e = mk(1, d, p, ok, sof, eol, md_ovf);
            if (eol) begin
                md_prev_q = md_cur_q; md_cur_q.delete(); md_first = 0; md_col = 0;
            end else begin
                md_col++;
            end
        end
        drive_check(v, d, sof, eol, e, tag);
    endtask

    task automatic send_line(input int len, input int base, input bit sof, input bit eol_last,
                             input int gap, input string tag);
        for (int c = 0; c < len; c++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) step(0, 8'($urandom), 0, 0, tag);
            step(1, 8'(base + c), sof && (c == 0), eol_last && (c == len - 1),
                 $sformatf("%s c%0d", tag, c));
        end
    endtask

    task automatic check_zero(input string tag);
        logic [3*DW+2*AW+7:0] got;
        got = {ram_din, ram_waddr, ram_we, ram_raddr, ram_ren, m_valid, m_cur, m_prev,
               m_prev_ok, m_sof, m_eol, ovf_err, 1'b0};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL %s: outputs=%h, required all zero", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; s_valid = 0; s_sof = 0; s_eol = 0; s_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 8'd99, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1, 8'd10, 1, 0, mk(1, 10, 0, 0, 1, 0, 0)};
        tbl[2]  = '{1, 8'd11, 0, 1, mk(1, 11, 0, 0, 0, 1, 0)};
        tbl[3]  = '{0, 8'd77, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1, 8'd20, 0, 0, mk(1, 20, 10, 1, 0, 0, 0)};
        tbl[5]  = '{1, 8'd21, 0, 0, mk(1, 21, 11, 1, 0, 0, 0)};
        tbl[6]  = '{1, 8'd22, 0, 1, mk(1, 22, 0, 0, 0, 1, 0)};
        tbl[7]  = '{1, 8'd30, 1, 1, mk(1, 30, 0, 0, 1, 1, 0)};
        tbl[8]  = '{1, 8'd31, 0, 1, mk(1, 31, 30, 1, 0, 1, 0)};
        tbl[9]  = '{1, 8'd40, 0, 0, mk(1, 40, 31, 1, 0, 0, 0)};
        tbl[10] = '{1, 8'd41, 0, 1, mk(1, 41, 0, 0, 0, 1, 0)};

        model_reset();
        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 11; i++)
            drive_check(tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].eol, tbl[i].exp, $sformatf("tbl%0d", i));

        // T1: 3 lines x 8, pixel = 16n+col
        do_reset();
        for (int n = 0; n < 3; n++) send_line(8, 16 * n, n == 0, 1, 0, $sformatf("T1 l%0d", n));

        // T2: 8-px line then 12-px line
        send_line(8, 100, 1, 1, 0, "T2 l0");
        send_line(12, 150, 0, 1, 0, "T2 l1");

        // T3: overflow with two 20-px lines, then a fresh frame clears it
        send_line(20, 0, 1, 1, 0, "T3 l0");
        send_line(20, 40, 0, 1, 0, "T3 l1");
        send_line(4, 200, 1, 1, 0, "T3 sof");

        // T4: 4x10 frame with 50% gaps
        for (int n = 0; n < 4; n++) send_line(10, 16 * n, n == 0, 1, 50, $sformatf("T4 l%0d", n));

        // T5: restart mid-line at col 5 of line 2
        send_line(8, 0, 1, 1, 0, "T5 l0");
        send_line(8, 16, 0, 1, 0, "T5 l1");
        send_line(5, 32, 0, 0, 0, "T5 l2");
        send_line(8, 64, 1, 1, 0, "T5 restart");
        send_line(8, 80, 0, 1, 0, "T5 next");

        // T6: reset at col 3 of line 1
        send_line(8, 0, 1, 1, 0, "T6 l0");
        send_line(3, 16, 0, 0, 0, "T6 l1");
        @(negedge clk);
        rst_n = 0; s_valid = 1; s_data = 8'd19; s_sof = 0; s_eol = 0;
        #1;
        check_zero("T6 rst_assert");
        @(posedge clk); #1;
        check_zero("T6 rst_hold");
        @(negedge clk);
        s_valid = 0;
        rst_n = 1;
        model_reset();
        step(1, 8'd55, 0, 0, "T6 idle_drop");
        send_line(6, 120, 1, 1, 0, "T6 new l0");
        send_line(6, 140, 0, 1, 0, "T6 new l1");

        // Random frames: random lengths incl. 1-px and overflow, gaps, occasional early restarts
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = $urandom_range(5, 2);
            for (int n = 0; n < nl; n++) begin
                int len;
                len = $urandom_range(4) == 0 ? 1 : $urandom_range(20, 1);
                send_line(len, $urandom_range(255), n == 0 || $urandom_range(9) == 0,
                          1, $urandom_range(60), $sformatf("R f%0d l%0d", f, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
